// File: rtl/freq_meas_ctrl.sv
// Gated frequency measurement sequencer: clears an external pulse counter, opens a
// timed counting window, waits out the counter pipeline and reports the raw count.
module freq_meas_ctrl #(
    parameter int unsigned GATE0_CYC  = 1_000_000,
    parameter int unsigned GATE1_CYC  = 10_000_000,
    parameter int unsigned GATE2_CYC  = 100_000_000,
    parameter int unsigned SETTLE_CYC = 4,
    parameter int unsigned LOW_THRESH = 1000
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        auto_range,
    input  logic [1:0]  range_sel,
    input  logic [31:0] cnt_val,
    output logic        cnt_clr,
    output logic        gate_en,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [1:0]  range_used
);

    localparam int unsigned CNT_W = 32;

    localparam logic [CNT_W-1:0] GATE0_LIM  = CNT_W'(GATE0_CYC);
    localparam logic [CNT_W-1:0] GATE1_LIM  = CNT_W'(GATE1_CYC);
    localparam logic [CNT_W-1:0] GATE2_LIM  = CNT_W'(GATE2_CYC);
    localparam logic [CNT_W-1:0] SETTLE_LIM = CNT_W'(SETTLE_CYC);
    localparam logic [CNT_W-1:0] THRESH     = CNT_W'(LOW_THRESH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        GATE   = 3'd2,
        SETTLE = 3'd3,
        EVAL   = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t           state;
    logic [1:0]       range_w;
    logic             auto_l;
    logic             relaunch;
    logic [CNT_W-1:0] gate_lim;
    logic [CNT_W-1:0] gate_cnt;
    logic [CNT_W-1:0] settle_cnt;
    logic [1:0]       range_clamped;

    function automatic logic [CNT_W-1:0] gate_len(input logic [1:0] r);
        case (r)
            2'd0:    gate_len = GATE0_LIM;
            2'd1:    gate_len = GATE1_LIM;
            default: gate_len = GATE2_LIM;
        endcase
    endfunction

    assign range_clamped = (range_sel == 2'd3) ? 2'd2 : range_sel;

    // Sequencer with all outputs registered alongside the state.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            range_w    <= 2'd0;
            auto_l     <= 1'b0;
            relaunch   <= 1'b0;
            gate_lim   <= '0;
            gate_cnt   <= '0;
            settle_cnt <= '0;
            cnt_clr    <= 1'b0;
            gate_en    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
            range_used <= 2'd0;
        end else if (abort && (state != IDLE)) begin
            state      <= IDLE;
            relaunch   <= 1'b0;
            gate_cnt   <= '0;
            settle_cnt <= '0;
            cnt_clr    <= 1'b0;
            gate_en    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        range_w  <= auto_range ? 2'd0 : range_clamped;
                        auto_l   <= auto_range;
                        gate_lim <= gate_len(auto_range ? 2'd0 : range_clamped);
                        relaunch <= 1'b0;
                        cnt_clr  <= 1'b1;
                        busy     <= 1'b1;
                        state    <= CLEAR;
                    end
                end
                CLEAR: begin
                    cnt_clr <= 1'b0;
                    // A step-up spends one extra cycle here so the clear settles before the new gate.
                    if (relaunch) begin
                        relaunch <= 1'b0;
                    end else begin
                        gate_cnt <= '0;
                        gate_en  <= 1'b1;
                        state    <= GATE;
                    end
                end
                GATE: begin
                    if (gate_cnt == gate_lim - CNT_W'(1)) begin
                        gate_cnt   <= '0;
                        settle_cnt <= '0;
                        gate_en    <= 1'b0;
                        state      <= SETTLE;
                    end else begin
                        gate_cnt <= gate_cnt + CNT_W'(1);
                    end
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_LIM - CNT_W'(1)) begin
                        settle_cnt <= '0;
                        state      <= EVAL;
                    end else begin
                        settle_cnt <= settle_cnt + CNT_W'(1);
                    end
                end
                EVAL: begin
                    if (auto_l && (cnt_val < THRESH) && (range_w != 2'd2)) begin
                        range_w  <= 2'(range_w + 2'd1);
                        gate_lim <= gate_len(2'(range_w + 2'd1));
                        relaunch <= 1'b1;
                        cnt_clr  <= 1'b1;
                        state    <= CLEAR;
                    end else begin
                        result     <= cnt_val;
                        range_used <= range_w;
                        done       <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    cnt_clr <= 1'b0;
                    gate_en <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_meas_ctrl.sv
// Directed bench for freq_meas_ctrl with short gates (10/100/1000), settle 4, threshold 8.
module tb_freq_meas_ctrl;

    logic        sys_clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic        auto_range;
    logic [1:0]  range_sel;
    logic [31:0] cnt_val;
    logic        cnt_clr;
    logic        gate_en;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [1:0]  range_used;

    int n_cmp = 0;
    int n_err = 0;

    freq_meas_ctrl #(
        .GATE0_CYC (10),
        .GATE1_CYC (100),
        .GATE2_CYC (1000),
        .SETTLE_CYC(4),
        .LOW_THRESH(8)
    ) dut (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .auto_range(auto_range),
        .range_sel (range_sel),
        .cnt_val   (cnt_val),
        .cnt_clr   (cnt_clr),
        .gate_en   (gate_en),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .range_used(range_used)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic        a;
        logic [1:0]  rs;
        logic [31:0] c1;
        logic [31:0] c2;
        logic        poke;
        int          lat;
        logic [31:0] res;
        logic [1:0]  rng;
        int          clrs;
        int          gates;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One measurement: start sampled at edge 0, observations at each following negedge.
    // cnt_val switches from c1 to c2 when the second cnt_clr pulse is seen.
    task automatic measure(input vec_t v, output int lat, output int clrs,
                           output int gates, output int first_gate);
        int cyc;
        @(negedge sys_clk);
        auto_range = v.a;
        range_sel  = v.rs;
        cnt_val    = v.c1;
        start      = 1'b1;
        @(negedge sys_clk);
        start      = 1'b0;
        cyc        = 1;
        lat        = -1;
        clrs       = 0;
        gates      = 0;
        first_gate = -1;
        while (cyc < 3000 && lat < 0) begin
            if (cnt_clr) begin
                clrs++;
                if (clrs == 2) cnt_val = v.c2;
            end
            if (gate_en) begin
                gates++;
                if (first_gate < 0) first_gate = cyc;
            end
            if (done) lat = cyc;
            if (v.poke && cyc == 5) begin
                auto_range = ~v.a;
                range_sel  = 2'd2;
                start      = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (lat < 0) begin
                @(negedge sys_clk);
                cyc++;
            end
        end
        start = 1'b0;
    endtask

    vec_t vecs[10];

    initial begin
        int lat, clrs, gates, fg, hits;
        vec_t v;

        vecs[0] = '{1'b0, 2'd0, 32'd50,  32'd50,  1'b0, 17,   32'd50,  2'd0, 1, 10};
        vecs[1] = '{1'b0, 2'd1, 32'd5,   32'd5,   1'b0, 107,  32'd5,   2'd1, 1, 100};
        vecs[2] = '{1'b0, 2'd3, 32'd123, 32'd123, 1'b0, 1007, 32'd123, 2'd2, 1, 1000};
        vecs[3] = '{1'b1, 2'd0, 32'd3,   32'd3,   1'b0, 1131, 32'd3,   2'd2, 3, 1110};
        vecs[4] = '{1'b1, 2'd0, 32'd3,   32'd20,  1'b0, 124,  32'd20,  2'd1, 2, 110};
        vecs[5] = '{1'b1, 2'd0, 32'd8,   32'd8,   1'b0, 17,   32'd8,   2'd0, 1, 10};
        vecs[6] = '{1'b1, 2'd0, 32'd7,   32'd8,   1'b0, 124,  32'd8,   2'd1, 2, 110};
        vecs[7] = '{1'b0, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 17, 32'hFFFF_FFFF, 2'd0, 1, 10};
        vecs[8] = '{1'b1, 2'd1, 32'd100, 32'd100, 1'b0, 17,   32'd100, 2'd0, 1, 10};
        vecs[9] = '{1'b0, 2'd0, 32'd50,  32'd50,  1'b1, 17,   32'd50,  2'd0, 1, 10};

        rst        = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        auto_range = 1'b0;
        range_sel  = 2'd0;
        cnt_val    = 32'd0;
        repeat (3) @(negedge sys_clk);
        check("rst_cnt_clr", 32'(cnt_clr), 32'd0);
        check("rst_gate_en", 32'(gate_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_range_used", 32'(range_used), 32'd0);
        rst = 1'b0;
        @(negedge sys_clk);

        for (int i = 0; i < 10; i++) begin
            measure(vecs[i], lat, clrs, gates, fg);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("v%0d_result", i), result, vecs[i].res);
            check($sformatf("v%0d_range_used", i), 32'(range_used), 32'(vecs[i].rng));
            check($sformatf("v%0d_clr_pulses", i), 32'(clrs), 32'(vecs[i].clrs));
            check($sformatf("v%0d_gate_cycles", i), 32'(gates), 32'(vecs[i].gates));
            check($sformatf("v%0d_first_gate", i), 32'(fg), 32'd2);
            @(negedge sys_clk);
            check($sformatf("v%0d_busy_after", i), 32'(busy), 32'd0);
            check($sformatf("v%0d_done_after", i), 32'(done), 32'd0);
        end

        // Start during the DONE cycle must be ignored.
        v = '{1'b0, 2'd0, 32'd42, 32'd42, 1'b0, 17, 32'd42, 2'd0, 1, 10};
        measure(v, lat, clrs, gates, fg);
        check("pre_abort_result", result, 32'd42);
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        check("start_in_done_busy", 32'(busy), 32'd0);
        @(negedge sys_clk);
        check("start_in_done_clr", 32'(cnt_clr), 32'd0);

        // Abort on the 5th gate cycle.
        auto_range = 1'b0;
        range_sel  = 2'd0;
        cnt_val    = 32'd99;
        start      = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        repeat (5) @(negedge sys_clk);
        check("abort_gate_before", 32'(gate_en), 32'd1);
        abort = 1'b1;
        @(negedge sys_clk);
        abort = 1'b0;
        check("abort_gate_en", 32'(gate_en), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        hits = 0;
        for (int i = 0; i < 30; i++) begin
            if (done || busy) hits++;
            @(negedge sys_clk);
        end
        check("abort_no_done", 32'(hits), 32'd0);
        check("abort_result_kept", result, 32'd42);
        check("abort_range_kept", 32'(range_used), 32'd0);

        // Abort and start together in IDLE: nothing starts.
        abort = 1'b1;
        start = 1'b1;
        @(negedge sys_clk);
        abort = 1'b0;
        start = 1'b0;
        check("abort_start_busy", 32'(busy), 32'd0);
        check("abort_start_clr", 32'(cnt_clr), 32'd0);

        // Reset in the middle of a range-1 gate.
        range_sel = 2'd1;
        cnt_val   = 32'd55;
        start     = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        repeat (10) @(negedge sys_clk);
        check("midrst_gate_before", 32'(gate_en), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_gate_en", 32'(gate_en), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_result", result, 32'd0);
        check("midrst_range_used", 32'(range_used), 32'd0);
        @(negedge sys_clk);
        rst = 1'b0;
        hits = 0;
        for (int i = 0; i < 150; i++) begin
            if (done || busy || gate_en) hits++;
            @(negedge sys_clk);
        end
        check("midrst_quiet", 32'(hits), 32'd0);
        v = '{1'b0, 2'd3, 32'd9, 32'd9, 1'b0, 1007, 32'd9, 2'd2, 1, 1000};
        measure(v, lat, clrs, gates, fg);
        check("postrst_latency", 32'(lat), 32'd1007);
        check("postrst_result", result, 32'd9);
        check("postrst_range_used", 32'(range_used), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
